alu_wide_sequencer: RTL and testbench

Multi-cycle controller that executes 32-bit arithmetic and logic operations on the shared 16-bit ALU.

- Each request is processed in two ALU passes:
  - low halves first;
  - then high halves, with the low-pass carry chained through `Cin`.
- Results and flags are registered and returned over a valid/ready response channel.
- The block sits between the execute stage (or any 32-bit requester) and the ALU instance, and owns the ALU ports for the whole of an operation.

---
 rtl/alu_wide_sequencer.sv | 120 ++++++++++++
 tb/tb_alu_wide_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alu_wide_sequencer.sv
// rtl/alu_wide_sequencer.sv - 32-bit operations sequenced as two passes over a shared 16-bit ALU
module alu_wide_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_func,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic        req_cin,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_s,
   output logic [3:0]  rsp_cvzn,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic        alu_cin,
   output logic [2:0]  alu_op_type,
   output logic [2:0]  alu_func,
   output logic [2:0]  alu_shift,
   input  logic [15:0] alu_s,
   input  logic [3:0]  alu_cvzn
);

   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] a_q, a_d, b_q, b_d, s_q, s_d;
   logic [2:0]  func_q, func_d;
   logic        cin_q, cin_d, c_lo_q, c_lo_d, z_lo_q, z_lo_d;
   logic [3:0]  cvzn_q, cvzn_d;

   assign alu_shift = 3'b000;
   assign rsp_s     = s_q;
   assign rsp_cvzn  = cvzn_q;

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      func_d      = func_q;
      cin_d       = cin_q;
      s_d         = s_q;
      cvzn_d      = cvzn_q;
      c_lo_d      = c_lo_q;
      z_lo_d      = z_lo_q;
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      alu_a       = 16'h0000;
      alu_b       = 16'h0000;
      alu_cin     = 1'b0;
      alu_op_type = 3'b000;
      alu_func    = 3'b000;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               a_d     = req_a;
               b_d     = req_b;
               func_d  = req_func;
               cin_d   = req_cin;
               state_d = LO;
            end
         end
         LO: begin
            alu_a       = a_q[15:0];
            alu_b       = b_q[15:0];
            alu_op_type = 3'b001;
            alu_func    = func_q;
            // Only ADC (5) and SBC (7) consume the external carry.
            alu_cin     = func_q[2] & func_q[0] & cin_q;
            s_d[15:0]   = alu_s;
            c_lo_d      = alu_cvzn[3];
            z_lo_d      = alu_cvzn[1];
            state_d     = HI;
         end
         HI: begin
            alu_a       = a_q[31:16];
            alu_b       = b_q[31:16];
            alu_op_type = 3'b001;
            // Arithmetic high pass always chains: ADD/ADC -> ADC, SUB/SBC -> SBC.
            alu_func    = func_q[2] ? {func_q[2:1], 1'b1} : func_q;
            alu_cin     = func_q[2] & c_lo_q;
            s_d[31:16]  = alu_s;
            cvzn_d      = {alu_cvzn[3], alu_cvzn[2], z_lo_q & alu_cvzn[1], alu_cvzn[0]};
            state_d     = DONE;
         end
         DONE: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= 32'h0;
         b_q     <= 32'h0;
         func_q  <= 3'b000;
         cin_q   <= 1'b0;
         s_q     <= 32'h0;
         cvzn_q  <= 4'h0;
         c_lo_q  <= 1'b0;
         z_lo_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         func_q  <= func_d;
         cin_q   <= cin_d;
         s_q     <= s_d;
         cvzn_q  <= cvzn_d;
         c_lo_q  <= c_lo_d;
         z_lo_q  <= z_lo_d;
      end
   end

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// tb/tb_alu_wide_sequencer.sv - directed vector bench for alu_wide_sequencer with a 16-bit ALU model
module tb_alu_wide_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_cin, rsp_valid, rsp_ready;
   logic [2:0]  req_func;
   logic [31:0] req_a, req_b, rsp_s;
   logic [3:0]  rsp_cvzn, alu_cvzn;
   logic [15:0] alu_a, alu_b, alu_s;
   logic        alu_cin;
   logic [2:0]  alu_op_type, alu_func, alu_shift;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   alu_wide_sequencer dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func),
      .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_s(rsp_s), .rsp_cvzn(rsp_cvzn),
      .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op_type(alu_op_type),
      .alu_func(alu_func), .alu_shift(alu_shift), .alu_s(alu_s), .alu_cvzn(alu_cvzn)
   );

   // 16-bit ALU model: responds only to op class 001
   logic [15:0] m_bop;
   logic [16:0] m_sum;
   logic        m_ci;
   always_comb begin
      m_bop    = alu_func[1] ? ~alu_b : alu_b;
      m_ci     = alu_func[0] ? alu_cin : alu_func[1];
      m_sum    = {1'b0, alu_a} + {1'b0, m_bop} + {16'h0, m_ci};
      alu_s    = 16'h0;
      alu_cvzn = 4'h0;
      if (alu_op_type == 3'b001) begin
         case (alu_func)
            3'd0: alu_s = alu_a & alu_b;
            3'd1: alu_s = alu_a | alu_b;
            3'd2: alu_s = alu_a ^ alu_b;
            3'd3: alu_s = alu_a & ~alu_b;
            default: alu_s = m_sum[15:0];
         endcase
         alu_cvzn[1] = (alu_s == 16'h0);
         alu_cvzn[0] = alu_s[15];
         if (alu_func[2]) begin
            alu_cvzn[3] = m_sum[16];
            alu_cvzn[2] = (alu_a[15] == m_bop[15]) && (m_sum[15] != alu_a[15]);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [2:0]  func;
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic        lo_cin;
      logic [2:0]  hi_func;
      logic        hi_cin;
      logic [31:0] s;
      logic [3:0]  cvzn;
   } vec_t;

   vec_t vecs[14];

   task automatic run_vec(input vec_t v, input int idx);
      string t;
      t = $sformatf("v%0d", idx);
      req_func  = v.func;
      req_a     = v.a;
      req_b     = v.b;
      req_cin   = v.cin;
      req_valid = 1'b1;
      check({t, " req_ready idle"}, {31'h0, req_ready}, 32'h1);
      tick;
      req_valid = 1'b0;
      check({t, " lo op_type"}, {29'h0, alu_op_type}, 32'h1);
      check({t, " lo func"}, {29'h0, alu_func}, {29'h0, v.func});
      check({t, " lo cin"}, {31'h0, alu_cin}, {31'h0, v.lo_cin});
      check({t, " lo a/b"}, {alu_a, alu_b}, {v.a[15:0], v.b[15:0]});
      check({t, " lo req_ready"}, {31'h0, req_ready}, 32'h0);
      tick;
      check({t, " hi func"}, {29'h0, alu_func}, {29'h0, v.hi_func});
      check({t, " hi cin"}, {31'h0, alu_cin}, {31'h0, v.hi_cin});
      check({t, " hi a/b"}, {alu_a, alu_b}, {v.a[31:16], v.b[31:16]});
      check({t, " hi rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
      tick;
      check({t, " rsp_valid"}, {31'h0, rsp_valid}, 32'h1);
      check({t, " rsp_s"}, rsp_s, v.s);
      check({t, " rsp_cvzn"}, {28'h0, rsp_cvzn}, {28'h0, v.cvzn});
      check({t, " done alu idle"}, {alu_op_type, alu_func, alu_a, alu_b[9:0]}, 32'h0);
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
      check({t, " back idle"}, {30'h0, rsp_valid, req_ready}, 32'h1);
   endtask

   logic [31:0] held_s;
   logic [3:0]  held_f;

   initial begin
      //            func  a             b             cin lo  hf  hc  s             cvzn
      vecs[0]  = '{3'd0, 32'hF0F01234, 32'hFF0000FF, 0, 0, 3'd0, 0, 32'hF0000034, 4'b0001};
      vecs[1]  = '{3'd1, 32'h00000000, 32'h00000000, 0, 0, 3'd1, 0, 32'h00000000, 4'b0010};
      vecs[2]  = '{3'd2, 32'h12345678, 32'h12345678, 0, 0, 3'd2, 0, 32'h00000000, 4'b0010};
      vecs[3]  = '{3'd2, 32'h00010000, 32'h00000000, 0, 0, 3'd2, 0, 32'h00010000, 4'b0000};
      vecs[4]  = '{3'd3, 32'hFFFFFFFF, 32'h0F0F0F0F, 1, 0, 3'd3, 0, 32'hF0F0F0F0, 4'b0001};
      vecs[5]  = '{3'd4, 32'h0000FFFF, 32'h00000001, 0, 0, 3'd5, 1, 32'h00010000, 4'b0000};
      vecs[6]  = '{3'd4, 32'h7FFFFFFF, 32'h00000001, 0, 0, 3'd5, 1, 32'h80000000, 4'b0101};
      vecs[7]  = '{3'd6, 32'h00000000, 32'h00000001, 0, 0, 3'd7, 0, 32'hFFFFFFFF, 4'b0001};
      vecs[8]  = '{3'd6, 32'h00000005, 32'h00000005, 0, 0, 3'd7, 1, 32'h00000000, 4'b1010};
      vecs[9]  = '{3'd5, 32'hFFFFFFFF, 32'h00000000, 1, 1, 3'd5, 1, 32'h00000000, 4'b1010};
      vecs[10] = '{3'd7, 32'h00000010, 32'h00000001, 0, 0, 3'd7, 1, 32'h0000000E, 4'b1000};
      vecs[11] = '{3'd4, 32'h00000001, 32'h00000001, 1, 0, 3'd5, 0, 32'h00000002, 4'b0000};
      vecs[12] = '{3'd4, 32'h80000000, 32'h80000000, 0, 0, 3'd5, 0, 32'h00000000, 4'b1110};
      vecs[13] = '{3'd7, 32'h80000000, 32'h00000001, 1, 1, 3'd7, 0, 32'h7FFFFFFF, 4'b1100};

      rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
      req_func = 3'd0; req_a = 32'h0; req_b = 32'h0; req_cin = 1'b0;
      tick; tick;
      check("reset handshake", {30'h0, req_ready, rsp_valid}, 32'h2);
      check("reset rsp_s", rsp_s, 32'h0);
      check("reset rsp_cvzn", {28'h0, rsp_cvzn}, 32'h0);
      check("reset alu outs", {alu_op_type, alu_func, alu_shift, alu_cin, alu_a}, 32'h0);
      check("reset alu_b", {16'h0, alu_b}, 32'h0);
      rst = 1'b0;
      tick;

      for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

      // Backpressure: hold DONE with a competing request pending
      req_func = 3'd4; req_a = 32'h00001234; req_b = 32'h00000001; req_cin = 1'b0;
      req_valid = 1'b1;
      tick; tick; tick;
      held_s = rsp_s;
      held_f = rsp_cvzn;
      check("bp first rsp_s", held_s, 32'h00001235);
      req_a = 32'hABCD0000;
      for (int k = 0; k < 5; k++) begin
         check($sformatf("bp hold %0d valid/ready", k), {30'h0, rsp_valid, req_ready}, 32'h2);
         check($sformatf("bp hold %0d data", k), {rsp_s[27:0], rsp_cvzn}, {held_s[27:0], held_f});
         tick;
      end
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
      check("bp release idle", {30'h0, rsp_valid, req_ready}, 32'h1);
      tick;
      req_valid = 1'b0;
      check("bp next accepted", {16'h0, alu_a}, 32'h0);
      check("bp next in LO", {29'h0, alu_op_type}, 32'h1);
      tick;
      check("bp next hi a", {16'h0, alu_a}, 32'h0000ABCD);
      tick;
      check("bp next rsp_s", rsp_s, 32'hABCD0001);
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;

      // Reset during the HI pass of an SBC
      req_func = 3'd7; req_a = 32'h12345678; req_b = 32'h00000001; req_cin = 1'b1;
      req_valid = 1'b1;
      tick;
      req_valid = 1'b0;
      tick;
      check("pre-reset in HI", {29'h0, alu_op_type}, 32'h1);
      #2 rst = 1'b1;
      #1;
      check("reset mid-op op_type", {29'h0, alu_op_type}, 32'h0);
      check("reset mid-op rsp_valid", {31'h0, rsp_valid}, 32'h0);
      check("reset mid-op rsp_s", rsp_s, 32'h0);
      tick;
      rst = 1'b0;
      tick;
      check("post-reset no rsp", {30'h0, rsp_valid, req_ready}, 32'h1);
      run_vec(vecs[9], 99);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
